ram_prog_loader: RTL
====================

// Module: ram_prog_loader
// PURPOSE
//  Byte-stream program loader: the write-side counterpart of the CPU's instruction fetch.
//  Takes bytes over a valid/ready link and packs them into 16-bit words.
//  Writes the words to the 256x16 program RAM, reads the region back to check a sum, then
//  releases the CPU from reset with start_pc pointing at the loaded image.
//  Sits between the host link and the RAM port mux. CPU reset is held low until a good load.
// PARAMETERS
//  ADDR_W  8   RAM address width (address arithmetic wraps mod 2**ADDR_W)
//  DATA_W  16  RAM word width (always 2 bytes)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       reset: synchronous, active-low
//  go         in   1       start pulse; sampled only in IDLE or DONE
//  base_addr  in   ADDR_W  first RAM word address; captured on go
//  word_count in   9       words to load; captured on go; legal 0..256
//  in_valid   in   1       byte valid from host
//  in_data    in   8       byte data; high byte of each word first
//  in_ready   out  1       loader can take a byte
//  ram_addr   out  ADDR_W  RAM address (drives both RAM r_addr and w_addr)
//  ram_w_en   out  1       RAM write strobe, single cycle
//  ram_w_data out  DATA_W  RAM write data
//  ram_r_data in   DATA_W  RAM read data, registered (valid 1 cycle after ram_addr)
//  busy       out  1       load or verify in progress
//  done       out  1       level; high in DONE state
//  error      out  1       bad count or checksum mismatch; valid while done
//  checksum   out  DATA_W  mod-2^16 sum of written words
//  cpu_rst_n  out  1       CPU reset, active-low
//  start_pc   out  ADDR_W  = captured base_addr
// BEHAVIOUR
//  Reset: all outputs 0 (incl. cpu_rst_n=0), state IDLE, internal sums and index cleared.
//  rst_n low at any time aborts the load at once. Partially written RAM is left as is.
//  States: IDLE, HI, LO, WR, VRD, VDRAIN, DONE.
//  IDLE/DONE + go: capture base and count; drive cpu_rst_n=0, done=0, error=0; clear sums, idx=0.
//   count=0 -> DONE (error=0). count>256 -> DONE (error=1). Otherwise -> HI.
//  HI: in_ready=1. On in_valid&in_ready, latch byte as word[15:8] and go to LO. Otherwise stay.
//  LO: in_ready=1. On handshake, word[7:0]=byte and go to WR.
//  WR: in_ready=0. For exactly 1 cycle: ram_w_en=1, ram_addr=base+idx (wraps), ram_w_data=word.
//   In the same cycle: wsum+=word, idx++. If idx+1==count, go to VRD with idx=0; else go to HI.
//  Throughput: at best 1 word per 3 cycles. in_valid gaps stall in HI/LO with no side effects.
//  VRD: drive ram_addr=base+idx for count consecutive cycles, no writes.
//   rsum adds ram_r_data one cycle after each address. After the last address, go to VDRAIN.
//  VDRAIN: add the final read, go to DONE. Set error = (rsum_final != wsum).
//  DONE: done=1, busy=0, checksum=wsum. cpu_rst_n=1 if error=0, else held 0.
//   Stays in DONE until go or reset. A go in DONE drops cpu_rst_n the next cycle.
//  busy=1 in HI/LO/WR/VRD/VDRAIN. go is ignored while busy.
//  ram_w_en is 0 in every state except WR. ram_addr holds its last value in IDLE/DONE.
//  Latency: go at cycle t -> in_ready=1 at t+1. Last WR at w -> done at w+count+2.
// TESTING
//  go base=0x10 cnt=2, bytes 12,34,AB,CD -> writes 0x1234@0x10 and 0xABCD@0x11;
//   checksum=0xBE01, error=0, cpu_rst_n=1, start_pc=0x10.
//  base=0xFF cnt=2 -> writes at 0xFF then 0x00 (wrap); verify reads 0xFF then 0x00; error=0.
//  cnt=0 -> done=1 one cycle after go, no ram_w_en, cpu_rst_n=1. cnt=300 -> done=1, error=1,
//   cpu_rst_n=0.
//  Random in_valid gaps, cnt=4 -> same RAM contents and checksum as gap-free run;
//   exactly 4 ram_w_en pulses.
//  RAM model corrupts the readback of word 1 -> error=1, cpu_rst_n stays 0, checksum=wsum.
//  rst_n low after 3 bytes of cnt=2 -> all outputs 0 next cycle; a new go restarts
//   at idx 0 and loads cleanly.

Source files
------------

// File: rtl/ram_prog_loader.sv
// Byte-stream program loader: packs host bytes into 16-bit words, writes them to program RAM,
// reads the region back to confirm the sum, then releases the CPU from reset.
module ram_prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [8:0]        word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HI     = 3'd1;
  localparam logic [2:0] S_LO     = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_VRD    = 3'd4;
  localparam logic [2:0] S_VDRAIN = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [8:0]        count_q, count_d;
  logic [8:0]        idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] wsum_q, wsum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic              rd_pend_q, rd_pend_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-1:0] addr_cur;
  logic [8:0]        idx_inc;
  logic [DATA_W-1:0] rsum_nxt;

  assign addr_cur = base_q + idx_q[ADDR_W-1:0];
  assign idx_inc  = idx_q + 9'd1;
  assign rsum_nxt = rsum_q + ram_r_data;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    word_d    = word_q;
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    err_d     = err_q;
    // Registered RAM: the word for each verify address arrives one cycle later.
    rd_pend_d = (state_q == S_VRD);
    if (rd_pend_q) rsum_d = rsum_nxt;

    ram_addr = addr_q;
    if (state_q == S_WR || state_q == S_VRD) ram_addr = addr_cur;
    addr_d = ram_addr;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          base_d    = base_addr;
          count_d   = word_count;
          idx_d     = '0;
          wsum_d    = '0;
          rsum_d    = '0;
          rd_pend_d = 1'b0;
          err_d     = 1'b0;
          if (word_count == 9'd0) begin
            state_d = S_DONE;
          end else if (word_count > 9'd256) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (in_valid) begin
          word_d[DATA_W-1 -: 8] = in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (in_valid) begin
          word_d[7:0] = in_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        wsum_d = wsum_q + word_q;
        if (idx_inc == count_q) begin
          idx_d   = '0;
          state_d = S_VRD;
        end else begin
          idx_d   = idx_inc;
          state_d = S_HI;
        end
      end
      S_VRD: begin
        idx_d = idx_inc;
        if (idx_inc == count_q) state_d = S_VDRAIN;
      end
      S_VDRAIN: begin
        err_d   = (rsum_nxt != wsum_q);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      wsum_q    <= '0;
      rsum_q    <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
    end
  end

  assign in_ready   = (state_q == S_HI) || (state_q == S_LO);
  assign ram_w_en   = (state_q == S_WR);
  assign ram_w_data = (state_q == S_WR) ? word_q : '0;
  assign busy       = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WR) ||
                      (state_q == S_VRD) || (state_q == S_VDRAIN);
  assign done       = (state_q == S_DONE);
  assign error      = err_q;
  assign checksum   = wsum_q;
  assign cpu_rst_n  = (state_q == S_DONE) && !err_q;
  assign start_pc   = base_q;

endmodule
